uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 10 +
 rtl/uart_rx_fifo_if.sv | 35 +++
 rtl/uart_rx_fifo_edge.sv | 23 ++
 rtl/uart_rx_fifo.sv | 88 ++++++++
 tb/tb_uart_rx_fifo.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-side types and defaults.
// Used by the receive FIFO, its interface and its edge detector.
package uart_rx_fifo_pkg;

  localparam int DATA_AMOUNT_DEF = 8;
  localparam int DEPTH_DEF       = 16;

  typedef logic [DATA_AMOUNT_DEF-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle between uart_rx_fifo and its neighbours: the receiver byte input,
// the consumer valid/ready port and the status/overflow lines.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_AMOUNT = DATA_AMOUNT_DEF,
  parameter int DEPTH       = DEPTH_DEF
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Consumer handshake: the head byte is taken on any cycle where valid_o and
  // ready_i are both high; data_o holds still while valid_o is high and
  // ready_i is low, and ready_i may change on any cycle.
  logic                   rx_valid_i;
  logic [DATA_AMOUNT-1:0] rx_data_i;
  logic                   valid_o;
  logic [DATA_AMOUNT-1:0] data_o;
  logic                   ready_i;
  logic [ADDR_W:0]        count_o;
  logic                   full_o;
  logic                   ovf_o;
  logic                   clr_ovf_i;

  modport master (
    output rx_valid_i, rx_data_i, ready_i, clr_ovf_i,
    input  valid_o, data_o, count_o, full_o, ovf_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, ready_i, clr_ovf_i,
    output valid_o, data_o, count_o, full_o, ovf_o
  );

endinterface

// File: rtl/uart_rx_fifo_edge.sv
// Single-flop rising-edge detector; the reset value of the history flop
// decides whether a level already high out of reset counts as an edge.
module rise_edge_detector
  import uart_rx_fifo_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) sig_q <= RST_VAL;
    else          sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver: one write per
// rising edge of the receiver valid level, sticky overflow on a dropped byte.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_AMOUNT = DATA_AMOUNT_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic           clk_i,
  input  logic           arstn_i,
  uart_rx_fifo_if.slave  bus
);

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_AMOUNT-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [ADDR_W:0]        count_q;
  logic [ADDR_W:0]        count_next;
  logic                   full_q;
  logic                   ovf_q;

  logic wr_stb;
  logic wr_en;
  logic rd_fire;
  logic drop;
  logic head_valid;

  // History flop resets high so a receiver already asserting valid is ignored.
  rise_edge_detector #(.RST_VAL(1'b1)) u_wr_edge (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .sig_i   (bus.rx_valid_i),
    .rise_o  (wr_stb)
  );

  assign head_valid = (count_q != '0);
  assign rd_fire    = head_valid & bus.ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en      = wr_stb & (~full_q | rd_fire);
  assign drop       = wr_stb & full_q & ~rd_fire;

  always_comb begin
    count_next = count_q;
    case ({wr_en, rd_fire})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_next;
      full_q  <= (count_next == FULL_CNT);
    end
  end

  // Storage carries no reset; nothing is visible until count_q says so.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= bus.rx_data_i;
  end

  // A new drop outranks a clear arriving in the same cycle.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)           ovf_q <= 1'b0;
    else if (drop)          ovf_q <= 1'b1;
    else if (bus.clr_ovf_i) ovf_q <= 1'b0;
  end

  assign bus.valid_o = head_valid;
  assign bus.data_o  = head_valid ? mem[rd_ptr] : '0;
  assign bus.count_o = count_q;
  assign bus.full_o  = full_q;
  assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table for reset/first capture, hand sequences
// for full/overflow corners, random bursts, and a queue model checked every cycle.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk;
  logic arstn;

  uart_rx_fifo_if #(.DATA_AMOUNT(8), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_AMOUNT(8), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic       prev_rx_m   = 1'b1;
  logic       ovf_m       = 1'b0;
  logic [7:0] last_pop    = 8'h00;
  int         pops        = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs compared on the falling edge, then the model steps for the next rising edge.
  always @(negedge clk) begin
    if (!arstn) begin
      exp_q.delete();
      prev_rx_m = 1'b1;
      ovf_m     = 1'b0;
    end else begin
      int  sz;
      logic rd_m, stb_m, full_m;
      sz = exp_q.size();
      check("mon_count", int'(bus.count_o), sz);
      check("mon_valid", int'(bus.valid_o), int'(sz != 0));
      check("mon_full",  int'(bus.full_o),  int'(sz == DEPTH));
      check("mon_ovf",   int'(bus.ovf_o),   int'(ovf_m));
      check("mon_data",  int'(bus.data_o),  (sz != 0) ? int'(exp_q[0]) : 0);
      rd_m   = (sz != 0) && bus.ready_i;
      stb_m  = bus.rx_valid_i && !prev_rx_m;
      full_m = (sz == DEPTH);
      if (rd_m) begin
        last_pop = exp_q.pop_front();
        pops++;
      end
      if (stb_m && (!full_m || rd_m)) exp_q.push_back(bus.rx_data_i);
      if (stb_m && full_m && !rd_m) ovf_m = 1'b1;
      else if (bus.clr_ovf_i)       ovf_m = 1'b0;
      prev_rx_m = bus.rx_valid_i;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    repeat (hi) cyc();
    bus.rx_valid_i = 1'b0;
    cyc();
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    for (int k = 0; k < 200 && bus.count_o != 0; k++) cyc();
    bus.ready_i = 1'b0;
    check("drain_empty", int'(bus.count_o), 0);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) send_byte(base + 8'(i), 1);
    check("fill_count", int'(bus.count_o), DEPTH);
    check("fill_full",  int'(bus.full_o), 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rx_valid;
    uart_byte_t rx_data;
    logic       ready;
    int         exp_count;
    logic       exp_valid;
    uart_byte_t exp_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int base_pops;

    tbl[0] = '{1'b1, 8'h46, 1'b0, 0, 1'b0, 8'h00}; // held high out of reset: no capture
    tbl[1] = '{1'b0, 8'h46, 1'b0, 0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h46, 1'b0, 0, 1'b0, 8'h00}; // rise: strobe this cycle
    tbl[3] = '{1'b1, 8'h46, 1'b0, 1, 1'b1, 8'h46}; // visible one cycle later
    tbl[4] = '{1'b1, 8'h46, 1'b0, 1, 1'b1, 8'h46};
    tbl[5] = '{1'b1, 8'h46, 1'b0, 1, 1'b1, 8'h46};
    tbl[6] = '{1'b1, 8'h46, 1'b0, 1, 1'b1, 8'h46}; // fifth high cycle, still one entry
    tbl[7] = '{1'b0, 8'h46, 1'b0, 1, 1'b1, 8'h46};
    tbl[8] = '{1'b0, 8'h46, 1'b1, 1, 1'b1, 8'h46}; // pop
    tbl[9] = '{1'b0, 8'h46, 1'b0, 0, 1'b0, 8'h00};

    arstn          = 1'b0;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'h46;
    bus.ready_i    = 1'b0;
    bus.clr_ovf_i  = 1'b0;
    repeat (3) cyc();
    check("reset_count", int'(bus.count_o), 0);
    check("reset_ovf",   int'(bus.ovf_o), 0);
    arstn = 1'b1;

    // reset with valid held, then one long pulse
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid_i = tbl[i].rx_valid;
      bus.rx_data_i  = tbl[i].rx_data;
      bus.ready_i    = tbl[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_count", i), int'(bus.count_o), tbl[i].exp_count);
      check($sformatf("vec%0d_valid", i), int'(bus.valid_o), int'(tbl[i].exp_valid));
      check($sformatf("vec%0d_data",  i), int'(bus.data_o),  int'(tbl[i].exp_data));
      cyc();
    end
    bus.ready_i = 1'b0;

    // fill to full, drop 0xAA, drain in order
    fill(8'h01);
    send_byte(8'hAA, 3);
    check("ovf_after_drop", int'(bus.ovf_o), 1);
    check("count_after_drop", int'(bus.count_o), DEPTH);
    drain();
    check("drain_last", int'(last_pop), 8'h10);
    bus.clr_ovf_i = 1'b1;
    cyc();
    bus.clr_ovf_i = 1'b0;
    check("ovf_cleared", int'(bus.ovf_o), 0);

    // full, write and read on the same cycle
    fill(8'h20);
    bus.rx_data_i  = 8'h55;
    bus.rx_valid_i = 1'b1;
    bus.ready_i    = 1'b1;
    cyc();
    bus.rx_valid_i = 1'b0;
    bus.ready_i    = 1'b0;
    check("wr_rd_full_count", int'(bus.count_o), DEPTH);
    check("wr_rd_full_ovf",   int'(bus.ovf_o), 0);
    cyc();
    drain();
    check("wr_rd_full_last", int'(last_pop), 8'h55);

    // clear coincident with a new drop, then clear alone
    fill(8'h60);
    send_byte(8'h77, 1);
    check("ovf_set", int'(bus.ovf_o), 1);
    bus.rx_data_i  = 8'h78;
    bus.rx_valid_i = 1'b1;
    bus.clr_ovf_i  = 1'b1;
    cyc();
    bus.rx_valid_i = 1'b0;
    bus.clr_ovf_i  = 1'b0;
    check("ovf_set_wins", int'(bus.ovf_o), 1);
    cyc();
    bus.clr_ovf_i = 1'b1;
    cyc();
    bus.clr_ovf_i = 1'b0;
    check("ovf_clr_alone", int'(bus.ovf_o), 0);
    drain();
    check("ovf_test_last", int'(last_pop), 8'h6F);

    // reset mid-operation discards stored bytes
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    check("pre_reset_count", int'(bus.count_o), 2);
    arstn = 1'b0;
    cyc();
    check("mid_reset_count", int'(bus.count_o), 0);
    check("mid_reset_valid", int'(bus.valid_o), 0);
    arstn = 1'b1;
    cyc();
    check("post_reset_count", int'(bus.count_o), 0);

    // random bursts with random consumer stalls
    base_pops = pops;
    for (int n = 0; n < 100; n++) begin
      int hi, lo;
      hi = $urandom_range(1, 4);
      lo = $urandom_range(2, 6);
      bus.rx_data_i  = 8'($urandom_range(0, 255));
      bus.rx_valid_i = 1'b1;
      for (int k = 0; k < hi; k++) begin
        bus.ready_i = 1'($urandom_range(0, 1));
        cyc();
      end
      bus.rx_valid_i = 1'b0;
      for (int k = 0; k < lo; k++) begin
        bus.ready_i = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    drain();
    check("random_all_out", pops - base_pops, 100);
    check("random_no_ovf", int'(bus.ovf_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
